pm_seq_regs: RTL
================

Name: pm_seq_regs

Overview:
- Sequential register file of the 4-bit microprogram sequencer.
- Sits directly downstream of the 4:1 next-address mux. It captures the mux output `y` into the microprogram counter, and holds the address register and the subroutine stack.
- It drives three of the mux data inputs back: d0 = upc, d1 = ar, d2 = stk_top. d3 is the external direct address and is not handled here.
- Together with the mux this forms a 2909-style next-address loop.

Parameters:
- W, 4, address width; must match the mux data width.
- DEPTH, 4, stack depth; power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of the stack occupancy count (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- y_in  in  W  next address from the mux output y.
- cin  in  1  increment enable for upc.
- ar_din  in  W  address register load data.
- ar_ld  in  1  load ar from ar_din.
- fe  in  1  stack file enable.
- pup  in  1  stack direction when fe=1: 1 = push, 0 = pop.
- sclr  in  1  synchronous stack clear.
- upc  out  W  microprogram counter; feeds mux d0.
- ar  out  W  address register; feeds mux d1.
- stk_top  out  W  top-of-stack value; feeds mux d2.
- cout  out  1  carry out of y_in + cin; combinational.
- sp  out  CW  stack occupancy, 0..DEPTH.
- full  out  1  sp == DEPTH.
- empty  out  1  sp == 0.
- stk_err  out  1  one-cycle pulse on overflow or underflow.

Behaviour:
- Reset, asynchronous and taking effect immediately, including mid-operation:
  - upc = 0, ar = 0, sp = 0.
  - All stack entries = 0.
  - stk_err = 0, so empty = 1, full = 0, stk_top = 0.
- upc update, every clock: upc <= (y_in + cin) mod 2^W.
  - cout = carry bit of the same W+1-bit sum, combinational.
  - Example: y_in=F, cin=1 gives upc=0 next cycle, with cout=1 in the same cycle as the inputs.
- ar: loads ar_din on a clock with ar_ld=1, otherwise holds. Latency 1 cycle.
- Stack, with priority sclr > fe.
  - sclr=1: sp <= 0. Entries are not cleared. stk_err <= 0.
  - Push (fe=1, pup=1, not full): mem[sp] <= upc, using the current registered value before this edge's update; sp <= sp+1.
  - Pop (fe=1, pup=0, not empty): sp <= sp-1. The entry is left in place.
  - Push when full: no write, sp unchanged, stk_err <= 1 for one cycle.
  - Pop when empty: sp unchanged, stk_err <= 1 for one cycle.
  - Otherwise stk_err <= 0.
- stk_top: mem[sp-1] when sp>0, else 0. Combinational from registered state, so it is valid the cycle after a push or pop.
- Simultaneous events on one edge:
  - Push and upc update: the push stores the old upc, and upc takes y_in+cin.
  - ar_ld is independent of the stack ops.
  - Push/pop are mutually exclusive by encoding.
- Outputs carry no combinational path from y_in except cout.

Decomposition:
- Shared package pm_pkg:
  - PM_W = 4.
  - Mux select encodings: SEL_UPC=2'b00, SEL_AR=2'b01, SEL_STK=2'b10, SEL_DIR=2'b11.
  - Stack op enum: NOP / PUSH / POP / CLR.
- One natural sub-module: pm_lifo.
  - Contents: stack memory, sp, full/empty/err, stk_top.
  - Parameters: W, DEPTH.
  - Ports: clk, rst, push, pop, clr, din, and its status outputs.
- Top level holds upc, ar, the adder, and the fe/pup decode.

Test Plan:
1. Reset mid-run: set ar=9, sp=2, then assert rst asynchronously between edges -> upc/ar/sp read 0, empty=1, stk_top=0, without waiting for a clock edge.
2. Increment/wrap: y_in=E, cin=1 -> upc=F next cycle. Then y_in=F, cin=1 -> cout=1 during that cycle and upc=0 next. y_in=5, cin=0 -> upc=5.
3. AR load: ar_din=A, ar_ld=1 for one cycle -> ar=A and holds A after ar_ld drops while ar_din changes to 3.
4. Push/pop LIFO: push with upc=1,2,3,4 on consecutive cycles -> sp=4, full=1, stk_top=4. Pop four times -> stk_top 3,2,1,0, and empty=1 at the end.
5. Overflow/underflow: push while full -> stk_err=1 for exactly one cycle, sp=4, stk_top still 4. Pop while empty -> stk_err=1 for one cycle, sp=0.
6. Priority/simultaneity: sclr=1 with fe=1, pup=1 at sp=2 -> sp=0, no write. Push at upc=7 with y_in=8, cin=0 -> stk_top=7 and upc=8 after the same edge.

Source files
------------

// File: rtl/pm_seq_regs_pkg.sv
`default_nettype none
// ============================================================================
// Package : pm_pkg
// Shared constants and types for the 4-bit microprogram sequencer slice.
// Revision: 1.0 - initial release
// ============================================================================
package pm_pkg;

    localparam int PM_W = 4;

    localparam logic [1:0] SEL_UPC = 2'b00;
    localparam logic [1:0] SEL_AR  = 2'b01;
    localparam logic [1:0] SEL_STK = 2'b10;
    localparam logic [1:0] SEL_DIR = 2'b11;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        CLR  = 2'd3
    } stk_op_e;

    // Clear dominates the file-enable controls.
    function automatic stk_op_e stk_decode(input logic sclr, input logic fe, input logic pup);
        stk_op_e op;
        op = NOP;
        if (sclr)
            op = CLR;
        else if (fe)
            op = pup ? PUSH : POP;
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pm_seq_regs_if.sv
`default_nettype none
// ============================================================================
// Interface : pm_seq_regs_if
// Control/data bundle between the sequencer register file and its driver.
// Revision  : 1.0 - initial release
// ============================================================================
interface pm_seq_regs_if
    import pm_pkg::*;
#(
    parameter int W     = PM_W,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  y_in;
    logic          cin;
    logic [W-1:0]  ar_din;
    logic          ar_ld;
    logic          fe;
    logic          pup;
    logic          sclr;
    logic [W-1:0]  upc;
    logic [W-1:0]  ar;
    logic [W-1:0]  stk_top;
    logic          cout;
    logic [CW-1:0] sp;
    logic          full;
    logic          empty;
    logic          stk_err;

    modport master (
        output y_in, cin, ar_din, ar_ld, fe, pup, sclr,
        input  upc, ar, stk_top, cout, sp, full, empty, stk_err
    );

    modport slave (
        input  y_in, cin, ar_din, ar_ld, fe, pup, sclr,
        output upc, ar, stk_top, cout, sp, full, empty, stk_err
    );

endinterface
`default_nettype wire

// File: rtl/pm_seq_regs_lifo.sv
`default_nettype none
// ============================================================================
// Module  : pm_lifo
// Subroutine return stack with occupancy count and overflow/underflow pulse.
// Revision: 1.0 - initial release
// ============================================================================
module pm_lifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic                       clr,
    input  wire logic [W-1:0]               din,
    output logic      [W-1:0]               top,
    output logic      [$clog2(DEPTH):0]     sp,
    output logic                            full,
    output logic                            empty,
    output logic                            err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_sp;
    logic          r_err;

    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_sp_m1;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_top_idx;

    assign w_full    = (r_sp == CW'(DEPTH));
    assign w_empty   = (r_sp == '0);
    assign w_sp_m1   = r_sp - CW'(1);
    assign w_wr_idx  = r_sp[AW-1:0];
    assign w_top_idx = w_sp_m1[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp  <= '0;
            r_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (clr) begin
            // Entries are left stale; only sp is rewound.
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (push) begin
            if (w_full) begin
                r_err <= 1'b1;
            end else begin
                r_mem[w_wr_idx] <= din;
                r_sp            <= r_sp + CW'(1);
                r_err           <= 1'b0;
            end
        end else if (pop) begin
            if (w_empty) begin
                r_err <= 1'b1;
            end else begin
                r_sp  <= w_sp_m1;
                r_err <= 1'b0;
            end
        end else begin
            r_err <= 1'b0;
        end
    end

    assign top   = w_empty ? '0 : r_mem[w_top_idx];
    assign sp    = r_sp;
    assign full  = w_full;
    assign empty = w_empty;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: rtl/pm_seq_regs.sv
`default_nettype none
// ============================================================================
// Module  : pm_seq_regs
// Sequencer register file: microprogram counter, address register, stack.
// Revision: 1.0 - initial release
// ============================================================================
module pm_seq_regs
    import pm_pkg::*;
#(
    parameter int W     = PM_W,
    parameter int DEPTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pm_seq_regs_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  r_upc;
    logic [W-1:0]  r_ar;

    logic [W:0]    w_sum;
    stk_op_e       w_op;
    logic [W-1:0]  w_top;
    logic [CW-1:0] w_sp;
    logic          w_full;
    logic          w_empty;
    logic          w_err;

    assign w_sum = {1'b0, bus.y_in} + (W+1)'(bus.cin);
    assign w_op  = stk_decode(bus.sclr, bus.fe, bus.pup);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upc <= '0;
            r_ar  <= '0;
        end else begin
            r_upc <= w_sum[W-1:0];
            if (bus.ar_ld)
                r_ar <= bus.ar_din;
        end
    end

    // Push samples r_upc before this edge updates it.
    pm_lifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_op == PUSH),
        .pop   (w_op == POP),
        .clr   (w_op == CLR),
        .din   (r_upc),
        .top   (w_top),
        .sp    (w_sp),
        .full  (w_full),
        .empty (w_empty),
        .err   (w_err)
    );

    assign bus.upc     = r_upc;
    assign bus.ar      = r_ar;
    assign bus.cout    = w_sum[W];
    assign bus.stk_top = w_top;
    assign bus.sp      = w_sp;
    assign bus.full    = w_full;
    assign bus.empty   = w_empty;
    assign bus.stk_err = w_err;

endmodule
`default_nettype wire
